// File: rtl/pipeline_reg_vr_pkg.sv
// Shared definitions for the valid/ready pipeline register: default payload
// width and the per-edge action taken by the stage controller.
package pipeline_reg_vr_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;

   // What the stage does on the next rising edge.
   typedef enum logic [2:0] {
      OP_HOLD,        // main stalled, nothing arriving: keep everything
      OP_LOAD_INPUT,  // main empty/draining: take the incoming beat into main
      OP_DRAIN_SKID,  // main empty/draining: move the skid beat into main
      OP_FILL_SKID,   // main stalled: park the incoming beat in the skid entry
      OP_EMPTY_MAIN   // main draining with nothing to replace it
   } stage_op_e;

   // Skid has priority over a new input beat to keep strict FIFO order. While
   // the skid entry is full in_ready is low, so in_xfer is never set then.
   function automatic stage_op_e next_op(input logic main_valid,
                                         input logic out_ready,
                                         input logic skid_valid,
                                         input logic in_xfer);
      stage_op_e op;
      if (!main_valid || out_ready) begin
         if (skid_valid)   op = OP_DRAIN_SKID;
         else if (in_xfer) op = OP_LOAD_INPUT;
         else              op = OP_EMPTY_MAIN;
      end else begin
         if (in_xfer)      op = OP_FILL_SKID;
         else              op = OP_HOLD;
      end
      return op;
   endfunction

endpackage

// File: rtl/pipeline_reg_vr_if.sv
// Streaming valid/ready bus. The producer side uses the master modport, the
// consumer side the slave modport.
interface pipeline_reg_vr_if
   import pipeline_reg_vr_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipeline_reg_vr_entry.sv
// One storage slot of the pipeline register: a valid flag plus payload.
// load writes a new beat, clear drops the valid flag and keeps the payload so
// the data output holds its last value when idle.
module pipeline_reg_vr_entry
   import pipeline_reg_vr_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,   // asynchronous, active-high
   input  logic                  load,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] d,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data
);

   // Slot register: load beats clear; payload untouched on clear.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         valid <= 1'b0;
         // NOTE: the payload is reset only because out_data=0 after reset is
         // observable behaviour; a pure datapath register would not need it.
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= d;
      end else if (clear) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pipeline_reg_vr.sv
// One-stage valid/ready pipeline register with a single skid entry. Data,
// valid and ready are all driven from flops, so the stage breaks every timing
// path between producer and consumer while sustaining one beat per cycle.
module pipeline_reg_vr
   import pipeline_reg_vr_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,   // asynchronous, active-high despite the name
   pipeline_reg_vr_if.slave  in_if,
   pipeline_reg_vr_if.master out_if
);

   logic                  main_valid;
   logic [DATA_WIDTH-1:0] main_data;
   logic                  skid_valid;
   logic [DATA_WIDTH-1:0] skid_data;

   logic                  in_xfer;
   stage_op_e             op;
   logic                  main_load;
   logic                  main_clear;
   logic [DATA_WIDTH-1:0] main_d;
   logic                  skid_load;
   logic                  skid_clear;

   // in_ready comes straight from the skid flop, so out_ready never reaches it
   // combinationally.
   assign in_if.ready  = !skid_valid;
   assign in_xfer      = in_if.valid && !skid_valid;

   assign out_if.valid = main_valid;
   assign out_if.data  = main_data;

   // Next-edge control: translate the chosen action into slot load/clear strobes.
   // NOTE: every output gets a default before the case so no path leaves a
   // signal unassigned, which would infer a latch.
   always_comb begin
      main_load  = 1'b0;
      main_clear = 1'b0;
      main_d     = in_if.data;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      op         = next_op(main_valid, out_if.ready, skid_valid, in_xfer);
      case (op)
         OP_LOAD_INPUT: begin
            main_load = 1'b1;
         end
         OP_DRAIN_SKID: begin
            main_load  = 1'b1;
            main_d     = skid_data;
            skid_clear = 1'b1;
         end
         OP_FILL_SKID: begin
            skid_load = 1'b1;
         end
         OP_EMPTY_MAIN: begin
            main_clear = 1'b1;
         end
         default: ;
      endcase
   end

   pipeline_reg_vr_entry #(.DATA_WIDTH(DATA_WIDTH)) u_main (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (main_load),
      .clear (main_clear),
      .d     (main_d),
      .valid (main_valid),
      .data  (main_data)
   );

   pipeline_reg_vr_entry #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (skid_load),
      .clear (skid_clear),
      .d     (in_if.data),
      .valid (skid_valid),
      .data  (skid_data)
   );

endmodule

// File: tb/tb_pipeline_reg_vr.sv
// Self-checking bench for pipeline_reg_vr: directed reset/transfer/backpressure
// steps followed by a randomized stall run, all scored through a FIFO queue.
module tb_pipeline_reg_vr;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n;

   pipeline_reg_vr_if #(.DATA_WIDTH(W)) in_bus ();
   pipeline_reg_vr_if #(.DATA_WIDTH(W)) out_bus ();

   pipeline_reg_vr #(.DATA_WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .in_if  (in_bus),
      .out_if (out_bus)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          passes   = 0;
   int          received = 0;
   logic [W-1:0] sb[$];
   logic        stall_prev = 1'b0;
   logic [W-1:0] prev_data  = '0;
   logic        in_acc     = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock: sample at the falling edge (inputs and outputs stable), score
   // both sides, then step past the rising edge.
   task automatic cycle();
      logic [W-1:0] exp;
      @(negedge clk);
      if (stall_prev)
         check("stable", {out_bus.valid, out_bus.data}, {1'b1, prev_data});
      in_acc = in_bus.valid && in_bus.ready;
      if (out_bus.valid && out_bus.ready) begin
         if (sb.size() == 0) begin
            check("sb_nonempty", sb.size() != 0, 1);
         end else begin
            exp = sb.pop_front();
            check("sb_data", out_bus.data, exp);
            received++;
         end
      end
      if (in_acc) sb.push_back(in_bus.data);
      stall_prev = out_bus.valid && !out_bus.ready;
      prev_data  = out_bus.data;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int seq;
      int budget;

      rst_n        = 1'b1;
      in_bus.valid = 1'b0;
      in_bus.data  = '0;
      out_bus.ready = 1'b0;
      #1;
      check("rst_out_valid", out_bus.valid, 0);
      check("rst_out_data",  out_bus.data,  0);
      check("rst_in_ready",  in_bus.ready,  1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("rel_out_valid", out_bus.valid, 0);
      check("rel_in_ready",  in_bus.ready,  1);

      // Normal transfer
      in_bus.valid = 1'b1; in_bus.data = 32'hA5A5A5A5; out_bus.ready = 1'b1;
      cycle();
      check("norm_valid", out_bus.valid, 1);
      check("norm_data",  out_bus.data,  32'hA5A5A5A5);
      in_bus.valid = 1'b0;
      cycle();
      check("norm_idle_valid", out_bus.valid, 0);
      check("norm_idle_data",  out_bus.data,  32'hA5A5A5A5);

      // Backpressure: main fills, then skid, then in_ready drops
      out_bus.ready = 1'b0; in_bus.valid = 1'b1; in_bus.data = 32'h12345678;
      cycle();
      check("bp1_valid", out_bus.valid, 1);
      check("bp1_data",  out_bus.data,  32'h12345678);
      check("bp1_ready", in_bus.ready,  1);
      cycle();
      check("bp2_ready", in_bus.ready,  0);
      check("bp2_data",  out_bus.data,  32'h12345678);
      cycle();
      check("bp3_ready", in_bus.ready,  0);
      check("bp3_valid", out_bus.valid, 1);
      in_bus.valid = 1'b0; out_bus.ready = 1'b1;
      cycle();
      check("bp_drain_valid", out_bus.valid, 1);
      check("bp_drain_ready", in_bus.ready,  1);
      cycle();
      check("bp_empty_valid", out_bus.valid, 0);
      check("bp_sb_empty",    sb.size(),     0);

      // Continuous back-to-back beats
      in_bus.valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_bus.data = 32'h12345679 + i;
         cycle();
         check("cont_valid", out_bus.valid, 1);
         check("cont_data",  out_bus.data,  32'h12345679 + i);
      end
      in_bus.valid = 1'b0;
      cycle();
      check("cont_end_valid", out_bus.valid, 0);

      // Reset mid-stream with both entries full
      out_bus.ready = 1'b0; in_bus.valid = 1'b1;
      in_bus.data = 32'hDEAD0001; cycle();
      in_bus.data = 32'hDEAD0002; cycle();
      check("pre_rst_ready", in_bus.ready, 0);
      in_bus.valid = 1'b0;
      #2;
      rst_n = 1'b1;
      #1;
      check("mid_rst_valid", out_bus.valid, 0);
      check("mid_rst_data",  out_bus.data,  0);
      check("mid_rst_ready", in_bus.ready,  1);
      sb.delete();
      stall_prev = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_valid", out_bus.valid, 0);
      check("post_rst_ready", in_bus.ready,  1);

      // Random stalls over 1000 beats; producer holds an unaccepted beat
      received = 0;
      seq      = 0;
      budget   = 0;
      in_bus.valid = 1'b0;
      while (received < 1000 && budget < 20000) begin
         if (!(in_bus.valid && !in_acc)) begin
            if (seq < 1000 && $urandom_range(0, 9) < 7) begin
               in_bus.valid = 1'b1;
               in_bus.data  = 32'hC000_0000 + seq;
               seq++;
            end else begin
               in_bus.valid = 1'b0;
               in_bus.data  = $urandom;
            end
         end
         out_bus.ready = ($urandom_range(0, 9) < 6);
         in_acc = 1'b0;
         cycle();
         budget++;
      end
      check("rand_count",    received,  1000);
      check("rand_sb_empty", sb.size(), 0);
      in_bus.valid = 1'b0; out_bus.ready = 1'b1;
      cycle();
      check("rand_idle_valid", out_bus.valid, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
